// File: rtl/counter_pkg.sv
// Shared state type and default timing constants for the up/down event generator.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLD,
    RPT
  } chan_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 10;
  localparam int DEF_REPEAT_PERIOD   = 3;

  localparam int STABLE_W = 8;
  localparam int TIMER_W  = 16;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debouncer and pulse/auto-repeat FSM.
// Auto-repeat after the first pulse is enabled by defining UPDOWN_AUTO_REPEAT_EN.
module btn_channel
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_level
);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  DELAY_LOAD  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0]  PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD - 1);

  logic [1:0]          r_sync;
  logic                r_level;
  logic [STABLE_W-1:0] r_stableCnt;
  chan_state_t         r_state;
  chan_state_t         w_stateNext;
  logic [TIMER_W-1:0]  r_timer;
  logic [TIMER_W-1:0]  w_timerNext;
  logic                w_accept;
  logic                w_rise;
  logic                w_fall;
  logic                w_pulse;

  assign w_accept = (r_sync[1] != r_level) && (r_stableCnt == STABLE_LAST);
  assign w_rise   = w_accept && !r_level;
  assign w_fall   = w_accept && r_level;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= '0;
      r_level     <= 1'b0;
      r_stableCnt <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if ((r_sync[1] == r_level) || w_accept) begin
        r_stableCnt <= '0;
      end else begin
        r_stableCnt <= r_stableCnt + STABLE_W'(1);
      end
      if (w_accept) begin
        r_level <= ~r_level;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_stateNext;
      r_timer <= w_timerNext;
    end
  end

  // The FSM moves on the same edge the debounced level changes, so a
  // release suppresses any pulse that would coincide with it.
  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    w_pulse     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_stateNext = FIRE;
        end
      end
      FIRE: begin
        w_pulse     = 1'b1;
        w_stateNext = HOLD;
        w_timerNext = DELAY_LOAD;
      end
      HOLD, RPT: begin
        if (r_timer == '0) begin
          w_timerNext = PERIOD_LOAD;
`ifdef UPDOWN_AUTO_REPEAT_EN
          w_pulse     = 1'b1;
          w_stateNext = RPT;
`else
          w_stateNext = HOLD;
`endif
        end else begin
          w_timerNext = r_timer - TIMER_W'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
    if (w_fall) begin
      w_stateNext = IDLE;
      w_timerNext = '0;
      w_pulse     = 1'b0;
    end
  end

  assign o_pulse = w_pulse;
  assign o_level = r_level;

endmodule

// File: rtl/updown_event_gen.sv
// Turns bouncy up/down buttons into one-cycle inc/dec strobes for an up/down counter.
// Auto-repeat (in btn_channel) is enabled by defining UPDOWN_AUTO_REPEAT_EN.
module updown_event_gen
  import counter_pkg::*;
#(
  parameter int INC_SIZE        = 1,
  parameter int DEC_SIZE        = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up_raw,
  input  logic                down_raw,
  output logic [INC_SIZE-1:0] inc,
  output logic [DEC_SIZE-1:0] dec,
  output logic                busy
);

  logic                w_upPulse;
  logic                w_upLevel;
  logic                w_downPulse;
  logic                w_downLevel;
  logic [INC_SIZE-1:0] r_inc;
  logic [DEC_SIZE-1:0] r_dec;

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_upChannel (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_raw  (up_raw),
    .o_pulse(w_upPulse),
    .o_level(w_upLevel)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_downChannel (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_raw  (down_raw),
    .o_pulse(w_downPulse),
    .o_level(w_downLevel)
  );

  // Simultaneous up and down events cancel so the counter sees no net change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc <= '0;
      r_dec <= '0;
    end else begin
      r_inc <= (w_upPulse && !w_downPulse) ? '1 : '0;
      r_dec <= (w_downPulse && !w_upPulse) ? '1 : '0;
    end
  end

  assign inc  = r_inc;
  assign dec  = r_dec;
  assign busy = w_upLevel | w_downLevel;

endmodule

// File: tb/tb_updown_event_gen.sv
// Directed bench for updown_event_gen: expected pulse cycles are queued as presses
// are driven and popped as the outputs are sampled. Honours UPDOWN_AUTO_REPEAT_EN.
module tb_updown_event_gen;

  localparam int D      = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;
  localparam int LAT    = D + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_raw;
  logic       down_raw;
  logic [0:0] inc;
  logic [0:0] dec;
  logic       busy;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int incQ[$];
  int decQ[$];
  int busyLo   = 0;
  int busyHi   = 0;

  updown_event_gen #(
    .INC_SIZE       (1),
    .DEC_SIZE       (1),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up_raw  (up_raw),
    .down_raw(down_raw),
    .inc     (inc),
    .dec     (dec),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic up, input logic down, input logic rstVal);
    up_raw   = up;
    down_raw = down;
    rst      = rstVal;
  endtask

  // Press driven at cycle c: first pulse at c+D+3, repeats (if enabled) up to pulseLimit.
  task automatic expectPress(input bit isUp, input int c, input int pulseLimit, input int busyEnd);
    int k;
    k = c + LAT;
    while (k <= pulseLimit) begin
      if (isUp) incQ.push_back(k);
      else      decQ.push_back(k);
`ifdef UPDOWN_AUTO_REPEAT_EN
      k += (k == c + LAT) ? DELAY : PERIOD;
`else
      k = pulseLimit + 1;
`endif
    end
    busyLo = c + D + 2;
    busyHi = busyEnd;
  endtask

  task automatic checkOutput();
    logic expInc;
    logic expDec;
    logic expBusy;
    expInc = 1'b0;
    expDec = 1'b0;
    if (incQ.size() > 0 && incQ[0] == cyc) begin
      expInc = 1'b1;
      void'(incQ.pop_front());
    end
    if (decQ.size() > 0 && decQ[0] == cyc) begin
      expDec = 1'b1;
      void'(decQ.pop_front());
    end
    expBusy = (cyc >= busyLo) && (cyc < busyHi);
    checks++;
    assert (inc[0] === expInc) else begin
      failures++;
      $error("[TB] FAIL inc cyc=%0d observed=%b expected=%b", cyc, inc, expInc);
    end
    checks++;
    assert (dec[0] === expDec) else begin
      failures++;
      $error("[TB] FAIL dec cyc=%0d observed=%b expected=%b", cyc, dec, expDec);
    end
    checks++;
    assert (busy === expBusy) else begin
      failures++;
      $error("[TB] FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, expBusy);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      checkOutput();
    end
  endtask

  initial begin
    int c;

    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);

    $display("[TB] clean up press");
    c = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPress(1'b1, c, c + 8 + D + 1, c + 8 + D + 2);
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(12);

    $display("[TB] clean down press");
    c = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectPress(1'b0, c, c + 8 + D + 1, c + 8 + D + 2);
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(12);

    $display("[TB] bouncing up input");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(2);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(2);
    end
    tick(10);

    $display("[TB] simultaneous up and down");
    c = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    busyLo = c + D + 2;
    busyHi = c + 8 + D + 2;
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(12);

    $display("[TB] long hold");
    c = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPress(1'b1, c, c + 40 + D + 1, c + 40 + D + 2);
    tick(40);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(15);

    $display("[TB] reset during held press");
    c = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPress(1'b1, c, c + 21, c + 22);
    tick(21);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    c = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPress(1'b1, c, c + 20 + D + 1, c + 20 + D + 2);
    tick(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(15);

    checks++;
    assert (incQ.size() == 0 && decQ.size() == 0) else begin
      failures++;
      $error("[TB] FAIL pending_pulses observed=%0d expected=0", incQ.size() + decQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_event_gen.md
UPDOWN_EVENT_GEN -- requirements
Module: updown_event_gen

Interface
REQ-001 Parameter INC_SIZE, default 1: width of inc output, matching the up/down counter's inc port.
REQ-002 Parameter DEC_SIZE, default 1: width of dec output, matching the counter's dec port.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required before a raw level change is accepted; legal range 1..255.
REQ-004 Parameter REPEAT_DELAY, default 10: cycles from first pulse to first auto-repeat pulse; legal range 2..65535.
REQ-005 Parameter REPEAT_PERIOD, default 3: cycles between successive auto-repeat pulses; legal range 2..65535.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 up_raw  input  1  asynchronous, bouncy "increment" request (button/switch).
REQ-009 down_raw  input  1  asynchronous, bouncy "decrement" request.
REQ-010 inc  output  INC_SIZE  to counter inc; all-ones for exactly one cycle per increment event, else zero.
REQ-011 dec  output  DEC_SIZE  to counter dec; all-ones for exactly one cycle per decrement event, else zero.
REQ-012 busy  output  1  high while either debounced channel is pressed.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each channel SHALL keep a debounced level that toggles only after the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching sample clears the stability counter.
REQ-015 Each channel SHALL run an FSM: IDLE -> (debounced rise) FIRE -> HOLD -> (REPEAT_DELAY elapsed) RPT; RPT reloads REPEAT_PERIOD per pulse; any state -> IDLE on debounced fall.
REQ-016 A channel pulse SHALL be emitted in FIRE and on each RPT timer expiry, one cycle wide, registered output.
REQ-017 Latency: up_raw held high from before rising edge N SHALL give inc all-ones during the cycle after edge N+DEBOUNCE_CYCLES+2.
REQ-018 If both channels pulse in the same cycle, inc and dec SHALL both be zero that cycle (events cancel); channel FSMs continue unaffected.
REQ-019 Release during HOLD or RPT SHALL stop all further pulses once the debounced level falls; no trailing pulse.
REQ-020 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no debounced transition.
REQ-021 Timers SHALL saturate-free reload; no wrap-around artefacts for any legal parameter value.

Reset
REQ-022 rst high at a rising edge SHALL force inc=0, dec=0, busy=0, both FSMs to IDLE, debounced levels to 0, synchronizers to 0, all timers to 0.
REQ-023 rst asserted mid-press SHALL suppress pulses; after release of rst a still-held input SHALL be treated as a new press (full debounce + FIRE).

Configuration
REQ-024 Macro UPDOWN_AUTO_REPEAT_EN: when defined, HOLD/RPT behaviour per REQ-015; when undefined, FSM stays in HOLD until release, exactly one pulse per press, REPEAT_DELAY/REPEAT_PERIOD ignored.

Structure
REQ-025 Shared package counter_pkg SHALL hold the channel state enum (IDLE, FIRE, HOLD, RPT) and default constants for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD.
REQ-026 Per-channel logic (sync, debounce, FSM, timers) SHALL be sub-module btn_channel, instantiated twice; top level does cancel logic and output registers.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, INC_SIZE=DEC_SIZE=1)
REQ-027 Clean press: up_raw high 8 cycles then low -> exactly one inc pulse, 7 cycles after first sampling edge; dec stays 0.
REQ-028 Bounce: up_raw toggles every 2 cycles for 20 cycles then low -> inc never asserted, busy stays 0.
REQ-029 Hold 40 cycles with UPDOWN_AUTO_REPEAT_EN -> pulses at FIRE, +10, +13, +16 ...; counter downstream increments by pulse count; none after release debounced.
REQ-030 Same hold without UPDOWN_AUTO_REPEAT_EN -> exactly one inc pulse.
REQ-031 up_raw and down_raw rise on same edge, held 8 cycles -> inc=0 and dec=0 every cycle.
REQ-032 rst pulsed 1 cycle during held up_raw in RPT -> no pulse for DEBOUNCE_CYCLES+3 cycles, then fresh FIRE pulse.
